// File: rtl/novacore_timer_pkg.sv
// Shared definitions for the multi-channel timer: register offsets,
// CONTROL/STATUS bit positions and the bus address split.
package novacore_timer_pkg;

    // Register offsets inside one channel's 8-word window
    typedef enum logic [2:0] {
        REG_STATUS   = 3'd0,
        REG_CONTROL  = 3'd1,
        REG_PERIOD   = 3'd2,
        REG_SNAP     = 3'd3,
        REG_PRESCALE = 3'd4
    } reg_offset_e;

    // STATUS bit positions
    localparam int STATUS_TO  = 0;
    localparam int STATUS_RUN = 1;

    // CONTROL bit positions (only ITO and CONT are stored)
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    // Widest address the block supports: up to 8 channels of 8 registers
    localparam int ADDR_MAX_W = 6;

    // Register offset is the low three address bits
    function automatic logic [2:0] addr_reg(input logic [ADDR_MAX_W-1:0] addr);
        return addr[2:0];
    endfunction

    // Channel index sits directly above the register offset
    function automatic logic [2:0] addr_ch(input logic [ADDR_MAX_W-1:0] addr);
        return addr[ADDR_MAX_W-1:3];
    endfunction

endpackage

// File: rtl/novacore_timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO flags and the
// channel's software-visible registers.
module novacore_timer_channel
    import novacore_timer_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int PRE_W      = 8,
    parameter int PERIOD_RST = 49999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [2:0]       reg_sel,
    input  logic [31:0]      writedata,
    output logic             run,
    output logic             to,
    output logic             cont,
    output logic             ito,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] snap,
    output logic [PRE_W-1:0] prescale
);

    logic [CNT_W-1:0] counter;
    logic [PRE_W-1:0] pcnt;
    logic             tick;
    logic             timeout;
    logic             wr_status;
    logic             wr_control;
    logic             wr_period;
    logic             wr_snap;
    logic             wr_prescale;

    assign wr_status   = wr_en && (reg_sel == REG_STATUS);
    assign wr_control  = wr_en && (reg_sel == REG_CONTROL);
    assign wr_period   = wr_en && (reg_sel == REG_PERIOD);
    assign wr_snap     = wr_en && (reg_sel == REG_SNAP);
    assign wr_prescale = wr_en && (reg_sel == REG_PRESCALE);

    // A tick ends each prescaler round; a PERIOD or PRESCALE write in the
    // same cycle restarts the round, so that tick is discarded
    assign tick    = run && (pcnt == prescale) && !wr_period && !wr_prescale;
    assign timeout = tick && (counter == '0);

    // Counter, prescaler, RUN/TO flags and register storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter  <= CNT_W'(PERIOD_RST);
            period   <= CNT_W'(PERIOD_RST);
            prescale <= '0;
            pcnt     <= '0;
            run      <= 1'b0;
            to       <= 1'b0;
            cont     <= 1'b0;
            ito      <= 1'b0;
            snap     <= '0;
        end else begin
            if (wr_period) begin
                period  <= writedata[CNT_W-1:0];
                counter <= writedata[CNT_W-1:0];
                pcnt    <= '0;
                run     <= 1'b0;
            end else if (wr_prescale) begin
                prescale <= writedata[PRE_W-1:0];
                pcnt     <= '0;
            end else begin
                if (run) begin
                    pcnt <= tick ? '0 : pcnt + 1'b1;
                end
                if (tick) begin
                    if (counter == '0) begin
                        counter <= period;
                        if (!cont) begin
                            run <= 1'b0;
                        end
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                if (wr_control) begin
                    cont <= writedata[CTRL_CONT];
                    ito  <= writedata[CTRL_ITO];
                    if (writedata[CTRL_START]) begin
                        run <= 1'b1;
                    end else if (writedata[CTRL_STOP]) begin
                        run <= 1'b0;
                    end
                end
            end

            if (timeout) begin
                to <= 1'b1;
            end else if (wr_status) begin
                to <= 1'b0;
            end

            if (wr_snap) begin
                snap <= counter;
            end
        end
    end

endmodule

// File: rtl/novacore_multi_timer.sv
// Multi-channel timer top: bus decode, per-channel instances, registered
// read mux and interrupt combining.
module novacore_multi_timer
    import novacore_timer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int PRE_W      = 8,
    parameter int PERIOD_RST = 49999
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [$clog2(NUM_CH)+3-1:0]  address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic [NUM_CH-1:0]            irq,
    output logic                         irq_any
);

    logic [ADDR_MAX_W-1:0] addr_ext;
    logic [2:0]            ch_sel;
    logic [2:0]            reg_sel;
    logic                  write_strobe;
    logic [31:0]           read_next;

    logic [NUM_CH-1:0]     run_v;
    logic [NUM_CH-1:0]     to_v;
    logic [NUM_CH-1:0]     cont_v;
    logic [NUM_CH-1:0]     ito_v;
    logic [CNT_W-1:0]      period_v   [NUM_CH];
    logic [CNT_W-1:0]      snap_v     [NUM_CH];
    logic [PRE_W-1:0]      prescale_v [NUM_CH];

    assign addr_ext     = ADDR_MAX_W'(address);
    assign ch_sel       = addr_ch(addr_ext);
    assign reg_sel      = addr_reg(addr_ext);
    assign write_strobe = chipselect && !write_n;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        novacore_timer_channel #(
            .CNT_W      (CNT_W),
            .PRE_W      (PRE_W),
            .PERIOD_RST (PERIOD_RST)
        ) u_channel (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr_en     (write_strobe && (ch_sel == 3'(c))),
            .reg_sel   (reg_sel),
            .writedata (writedata),
            .run       (run_v[c]),
            .to        (to_v[c]),
            .cont      (cont_v[c]),
            .ito       (ito_v[c]),
            .period    (period_v[c]),
            .snap      (snap_v[c]),
            .prescale  (prescale_v[c])
        );
    end

    assign irq     = to_v & ito_v;
    assign irq_any = |irq;

    // Select the addressed register; unused channels and offsets read as zero
    always_comb begin
        read_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 3'(c)) begin
                case (reg_sel)
                    REG_STATUS: begin
                        read_next[STATUS_RUN] = run_v[c];
                        read_next[STATUS_TO]  = to_v[c];
                    end
                    REG_CONTROL: begin
                        read_next[CTRL_CONT] = cont_v[c];
                        read_next[CTRL_ITO]  = ito_v[c];
                    end
                    REG_PERIOD:   read_next = 32'(period_v[c]);
                    REG_SNAP:     read_next = 32'(snap_v[c]);
                    REG_PRESCALE: read_next = 32'(prescale_v[c]);
                    default:      read_next = '0;
                endcase
            end
        end
    end

    // Read data is captured every cycle, independent of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= read_next;
        end
    end

endmodule

// File: tb/tb_novacore_multi_timer.sv
// Self-checking bench for novacore_multi_timer: register reads are checked
// through a queue of expected values, interrupt timing through cycle counts.
module tb_novacore_multi_timer;
    import novacore_timer_pkg::*;

    localparam int NUM_CH = 4;
    localparam int AW     = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [AW-1:0]     address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    novacore_multi_timer #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (32),
        .PRE_W      (8),
        .PERIOD_RST (49999)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_any    (irq_any)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus write: driven on a falling edge, taken on the next rising edge
    task automatic applyStimulus(input int ch, input logic [2:0] reg_sel, input logic [31:0] data);
        @(negedge clk);
        address    = {ch[1:0], reg_sel};
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = data;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // One bus read: expected value queued at issue, popped when readdata is valid
    task automatic readCheck(input int ch, input logic [2:0] reg_sel, input logic [31:0] exp,
                             input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        address    = {ch[1:0], reg_sel};
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        checkOutput(tag_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    // Count falling edges until irq[ch] rises, giving up after budget edges
    task automatic waitIrq(input int ch, input int budget, output int cycles);
        cycles = 0;
        while (irq[ch] !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          n;
        time         t1;
        time         t2;
        logic [3:0]  exp_irq;

        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset readdata", readdata, 32'd0);
        checkOutput("reset irq", {28'd0, irq}, 32'd0);
        checkOutput("reset irq_any", {31'd0, irq_any}, 32'd0);
        reset_n = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            readCheck(c, REG_PERIOD, 32'd49999, $sformatf("reset period ch%0d", c));
            readCheck(c, REG_STATUS, 32'd0, $sformatf("reset status ch%0d", c));
        end

        // Continuous mode, PERIOD=9, PRESCALE=0 on channel 0
        applyStimulus(0, REG_PERIOD, 32'd9);
        applyStimulus(0, REG_CONTROL, 32'h7);
        waitIrq(0, 40, n);
        t1 = $time;
        checkOutput("ch0 first timeout clocks", n, 32'd10);
        applyStimulus(0, REG_STATUS, 32'd0);
        checkOutput("ch0 irq after status clear", {31'd0, irq[0]}, 32'd0);
        waitIrq(0, 40, n);
        t2 = $time;
        checkOutput("ch0 timeout interval", 32'((t2 - t1) / 10), 32'd10);
        applyStimulus(0, REG_CONTROL, 32'h6);
        applyStimulus(0, REG_STATUS, 32'd0);
        repeat (12) @(negedge clk);
        checkOutput("ch0 irq masked by ITO", {31'd0, irq[0]}, 32'd0);
        readCheck(0, REG_STATUS, 32'h3, "ch0 status run+to with ITO=0");
        applyStimulus(0, REG_CONTROL, 32'h8);
        applyStimulus(0, REG_STATUS, 32'd0);
        readCheck(0, REG_STATUS, 32'h0, "ch0 status after stop");

        // One-shot with prescaler on channel 1
        applyStimulus(1, REG_PERIOD, 32'd4);
        applyStimulus(1, REG_PRESCALE, 32'd2);
        readCheck(1, REG_PRESCALE, 32'd2, "ch1 prescale readback");
        applyStimulus(1, REG_CONTROL, 32'h5);
        waitIrq(1, 60, n);
        checkOutput("ch1 one-shot clocks", n, 32'd15);
        readCheck(1, REG_STATUS, 32'h1, "ch1 status after one-shot");
        repeat (10) @(negedge clk);
        applyStimulus(1, REG_SNAP, 32'd0);
        readCheck(1, REG_SNAP, 32'd4, "ch1 counter held at period");
        applyStimulus(1, REG_CONTROL, 32'h0);
        applyStimulus(1, REG_STATUS, 32'd0);
        checkOutput("ch1 irq cleared", {31'd0, irq[1]}, 32'd0);

        // STATUS write colliding with a timeout on channel 2
        applyStimulus(2, REG_PERIOD, 32'd9);
        applyStimulus(2, REG_CONTROL, 32'h7);
        repeat (8) @(negedge clk);
        applyStimulus(2, REG_STATUS, 32'd0);
        checkOutput("ch2 TO survives same-cycle clear", {31'd0, irq[2]}, 32'd1);
        readCheck(2, REG_STATUS, 32'h3, "ch2 status after collision");
        applyStimulus(2, REG_STATUS, 32'd0);
        checkOutput("ch2 irq after later clear", {31'd0, irq[2]}, 32'd0);
        readCheck(2, REG_STATUS, 32'h2, "ch2 status run only");
        applyStimulus(2, REG_CONTROL, 32'h8);
        readCheck(2, REG_STATUS, 32'h0, "ch2 status stopped");

        // A strobe without chipselect must not write
        @(negedge clk);
        address    = {2'd2, REG_PERIOD};
        write_n    = 1'b0;
        writedata  = 32'd123;
        @(negedge clk);
        write_n    = 1'b1;
        readCheck(2, REG_PERIOD, 32'd9, "ch2 write without chipselect");

        // Snapshot, stop/hold/resume and force-reload on channel 2
        applyStimulus(2, REG_PERIOD, 32'd50);
        applyStimulus(2, REG_CONTROL, 32'h6);
        applyStimulus(2, REG_SNAP, 32'd0);
        readCheck(2, REG_SNAP, 32'd49, "ch2 live snapshot");
        applyStimulus(2, REG_CONTROL, 32'h8);
        repeat (20) @(negedge clk);
        applyStimulus(2, REG_SNAP, 32'd0);
        readCheck(2, REG_SNAP, 32'd44, "ch2 counter held while stopped");
        applyStimulus(2, REG_CONTROL, 32'h6);
        applyStimulus(2, REG_SNAP, 32'd0);
        readCheck(2, REG_SNAP, 32'd43, "ch2 counter resumes");
        applyStimulus(2, REG_PERIOD, 32'd100);
        readCheck(2, REG_STATUS, 32'h0, "ch2 run cleared by period write");
        applyStimulus(2, REG_SNAP, 32'd0);
        readCheck(2, REG_SNAP, 32'd100, "ch2 counter reloaded");
        readCheck(2, REG_PERIOD, 32'd100, "ch2 period readback");
        readCheck(2, REG_CONTROL, 32'h2, "ch2 control readback");
        applyStimulus(2, 3'd5, 32'hFFFF_FFFF);
        readCheck(2, 3'd5, 32'd0, "ch2 reserved register");

        // Channels 0 and 3 running side by side
        applyStimulus(0, REG_PERIOD, 32'd7);
        applyStimulus(3, REG_PERIOD, 32'd20);
        applyStimulus(0, REG_CONTROL, 32'h7);
        applyStimulus(3, REG_CONTROL, 32'hF);
        for (int k = 3; k <= 30; k++) begin
            @(negedge clk);
            exp_irq = {k >= 23, 1'b0, 1'b0, k >= 8};
            checkOutput($sformatf("irq vector cycle %0d", k), {28'd0, irq}, {28'd0, exp_irq});
            checkOutput($sformatf("irq_any cycle %0d", k), {31'd0, irq_any}, {31'd0, |exp_irq});
        end
        readCheck(3, REG_STATUS, 32'h3, "ch3 start wins over stop");
        readCheck(3, REG_CONTROL, 32'h3, "ch3 control stores low bits only");

        // Reset in the middle of a count with TO pending
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("mid reset readdata", readdata, 32'd0);
        checkOutput("mid reset irq", {28'd0, irq}, 32'd0);
        checkOutput("mid reset irq_any", {31'd0, irq_any}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        readCheck(0, REG_PERIOD, 32'd49999, "ch0 period after reset");
        readCheck(0, REG_STATUS, 32'd0, "ch0 status after reset");
        readCheck(0, REG_CONTROL, 32'd0, "ch0 control after reset");
        readCheck(0, REG_SNAP, 32'd0, "ch0 snap after reset");
        readCheck(3, REG_PERIOD, 32'd49999, "ch3 period after reset");
        repeat (20) @(negedge clk);
        readCheck(0, REG_STATUS, 32'd0, "ch0 no timeout after reset");
        checkOutput("irq_any after reset", {31'd0, irq_any}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/novacore_multi_timer.md
NOVACORE_MULTI_TIMER -- requirements
Module: novacore_multi_timer

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 Parameter CNT_W, default 32, counter and period width in bits (16..32).
REQ-003 Parameter PRE_W, default 8, prescaler width in bits.
REQ-004 Parameter PERIOD_RST, default 49999, reset value of every PERIOD register and counter.
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 address  input  $clog2(NUM_CH)+3  {channel, reg[2:0]}.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  NUM_CH  per-channel interrupt, irq[c] = TO[c] & ITO[c].
REQ-013 irq_any  output  1  OR of irq.

Function
REQ-014 Register map per channel: 0 STATUS {RUN bit1, TO bit0}; 1 CONTROL {STOP bit3, START bit2, CONT bit1, ITO bit0}, only bits 1:0 stored, 2,3 read back 0; 2 PERIOD [CNT_W-1:0]; 3 SNAP; 4 PRESCALE [PRE_W-1:0]; 5-7 reserved, read 0, writes ignored.
REQ-015 Write = chipselect & ~write_n; register updates on the following clock edge.
REQ-016 readdata SHALL equal the addressed register, zero-extended, one clock after the address is presented; updated every cycle regardless of chipselect.
REQ-017 Prescaler: per-channel counter PCNT counts 0..PRESCALE while RUN; tick asserted when PCNT==PRESCALE, then PCNT wraps to 0; PRESCALE=0 gives a tick every clock.
REQ-018 On tick: counter==0 -> counter loads PERIOD, TO set, RUN cleared if CONT=0; else counter decrements by 1.
REQ-019 Timeout interval SHALL be (PERIOD+1)*(PRESCALE+1) clocks.
REQ-020 Write CONTROL with START=1 sets RUN; with STOP=1 clears RUN; both set -> START wins.
REQ-021 Write PERIOD: next cycle counter loads new PERIOD, PCNT clears, RUN clears (force-reload).
REQ-022 Write PRESCALE: PCNT clears, counter and RUN unchanged.
REQ-023 Any write to STATUS clears TO; a timeout in the same cycle wins (TO stays 1).
REQ-024 Any write to SNAP copies the live counter into SNAP; reads return the captured value.
REQ-025 Stopped channel holds counter and PCNT; restart resumes from held value.
REQ-026 Channels fully independent; a write affects only the addressed channel.
REQ-027 irq and irq_any combinational from registered TO/ITO, no extra latency.

Reset
REQ-028 On reset_n low: counter=PERIOD=PERIOD_RST, PRESCALE=0, PCNT=0, RUN=0, TO=0, CONT=0, ITO=0, SNAP=0, readdata=0, irq=0, irq_any=0.
REQ-029 Reset asserted mid-count SHALL abort immediately; no timeout reported after release.

Structure
REQ-030 Shared package novacore_timer_pkg holds register offsets, CONTROL/STATUS bit positions and address-split helper.
REQ-031 One sub-module novacore_timer_channel (counter, prescaler, RUN/TO, registers) instanced NUM_CH times; top holds decode and read mux.

Verification
REQ-032 PERIOD=9, PRESCALE=0, CONT=1, START -> TO rises every 10 clocks; irq[c] only when ITO=1.
REQ-033 PERIOD=4, PRESCALE=2, CONT=0, START -> single TO after 15 clocks, RUN=0, counter holds 4.
REQ-034 STATUS write in same cycle as timeout -> TO remains 1; STATUS write next cycle -> TO=0, irq drops.
REQ-035 Running channel, write PERIOD=100 -> RUN=0 next cycle, counter=100; SNAP write then read SNAP returns 100.
REQ-036 Channels 0 and 3 run with different periods (7, 20) -> independent TO rates, irq_any = OR; CONTROL with START|STOP -> RUN=1.
REQ-037 reset_n low mid-count with TO=1 -> all outputs 0, PERIOD reads 49999 after release.
